// File: rtl/mul_arb_pkg.sv
// Shared widths and types for the multiplier-sharing arbiter: requester id,
// tag pipe entry and response FIFO entry.
package mul_arb_pkg;
  localparam int NREQ      = 4;
  localparam int W         = 64;
  localparam int RES_DEPTH = 4;
  localparam int IDW       = $clog2(NREQ);

  typedef logic [IDW-1:0] id_t;

  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  typedef struct packed {
    id_t          id;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } rsp_entry_t;

  function automatic logic [NREQ-1:0] id_onehot(input id_t id);
    return NREQ'(1) << id;
  endfunction
endpackage

// File: rtl/mul_share_arb_if.sv
// Requester, multiplier and response signals of mul_share_arb in one bundle.
// Every handshake here is valid&ready in the same cycle; valid never waits on ready.
interface mul_share_arb_if;
  import mul_arb_pkg::*;

  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*W-1:0] req_a_i;
  logic [NREQ*W-1:0] req_b_i;
  logic              mul_valid_o;
  logic [W-1:0]      mul_a_o;
  logic [W-1:0]      mul_b_o;
  logic              mul_res_valid_i;
  logic [W-1:0]      mul_hi_i;
  logic [W-1:0]      mul_lo_i;
  logic [NREQ-1:0]   rsp_valid_o;
  logic [NREQ-1:0]   rsp_ready_i;
  logic [W-1:0]      rsp_hi_o;
  logic [W-1:0]      rsp_lo_o;
  logic              busy_o;
  logic              err_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, mul_res_valid_i, mul_hi_i, mul_lo_i, rsp_ready_i,
    output req_ready_o, mul_valid_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_hi_o, rsp_lo_o,
           busy_o, err_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, mul_res_valid_i, mul_hi_i, mul_lo_i, rsp_ready_i,
    input  req_ready_o, mul_valid_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_hi_o, rsp_lo_o,
           busy_o, err_o
  );
endinterface

// File: rtl/mul_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; a push into a full FIFO
// is dropped and flagged unless a pop frees the slot in the same cycle.
module mul_rsp_fifo
  import mul_arb_pkg::*;
#(
  parameter int DEPTH = RES_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  rsp_entry_t                   din,
  input  logic                         pop,
  output rsp_entry_t                   dout,
  output logic                         empty,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  rsp_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (int'(count) == DEPTH);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mul_share_arb.sv
// Shares one fixed-latency pipelined multiplier among NREQ requesters with
// credit-gated issue and in-order routed responses. MUL_ARB_FIXED_PRIO_EN selects fixed priority.
module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  mul_share_arb_if.slave  bus
);
  localparam int IW = $clog2(MUL_LAT+1);

  tag_t                             tags [MUL_LAT];
  tag_t                             tail;
  id_t                              g;
  logic                             found, issue, credit_ok;
  logic [IW-1:0]                    inflight;
  logic [$clog2(RES_DEPTH+1)-1:0]   fifo_count;
  rsp_entry_t                       push_entry, head;
  logic                             push, pop, empty, overflow;
  logic                             err_q;

`ifdef MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    g     = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (bus.req_valid_i[i]) begin
        found = 1'b1;
        g     = id_t'(i);
      end
    end
  end
`else
  id_t rr_ptr;

  always_comb begin
    int idx;
    found = 1'b0;
    g     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && bus.req_valid_i[idx]) begin
        found = 1'b1;
        g     = id_t'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= '0;
    else if (issue) rr_ptr <= (int'(g) == NREQ-1) ? '0 : g + id_t'(1);
  end
`endif

  // Credit counts only registered state, so a pop this cycle frees a slot next cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) inflight = inflight + IW'(tags[i].vld);
  end

  assign credit_ok = (int'(fifo_count) + int'(inflight)) < RES_DEPTH;
  assign issue     = found & credit_ok & ~rst;

  assign bus.req_ready_o = issue ? id_onehot(g) : '0;
  assign bus.mul_valid_o = issue;
  assign bus.mul_a_o     = bus.req_a_i[int'(g)*W +: W];
  assign bus.mul_b_o     = bus.req_b_i[int'(g)*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{vld: issue, id: g};
      for (int i = 1; i < MUL_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  assign tail       = tags[MUL_LAT-1];
  assign push       = tail.vld & bus.mul_res_valid_i;
  assign push_entry = '{id: tail.id, hi: bus.mul_hi_i, lo: bus.mul_lo_i};

  mul_rsp_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (push_entry),
    .pop      (pop),
    .dout     (head),
    .empty    (empty),
    .overflow (overflow),
    .count    (fifo_count)
  );

  // Only the head's owner can release it; other readies are ignored.
  assign pop             = ~empty & bus.rsp_ready_i[head.id];
  assign bus.rsp_valid_o = (~empty & ~rst) ? id_onehot(head.id) : '0;
  assign bus.rsp_hi_o    = head.hi;
  assign bus.rsp_lo_o    = head.lo;
  assign bus.busy_o      = (inflight != '0) | ~empty;

  // A result without a tag or a tag without a result is dropped and latched as an error.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((bus.mul_res_valid_i ^ tail.vld) | overflow) err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a signed 3-stage multiplier model,
// a table of round-robin vectors and hand-written multi-cycle sequences.
module tb_mul_share_arb;
  import mul_arb_pkg::*;

  localparam int LAT = 3;
  localparam int EW  = IDW + 2*W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_share_arb_if bus();

  mul_share_arb #(.MUL_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Multiplier model: signed product, fixed latency, reset by the same rst
  logic           m_v [LAT];
  logic [2*W-1:0] m_p [LAT];
  logic           inject, drop;

  function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        m_v[i] <= 1'b0;
        m_p[i] <= '0;
      end
    end else begin
      m_v[0] <= bus.mul_valid_o;
      m_p[0] <= smul(bus.mul_a_o, bus.mul_b_o);
      for (int i = 1; i < LAT; i++) begin
        m_v[i] <= m_v[i-1];
        m_p[i] <= m_p[i-1];
      end
    end
  end

  assign bus.mul_res_valid_i = (m_v[LAT-1] & ~drop) | inject;
  assign bus.mul_hi_i        = m_p[LAT-1][2*W-1:W];
  assign bus.mul_lo_i        = m_p[LAT-1][W-1:0];

  // Scoreboard
  int            n_vec = 0;
  int            n_err = 0;
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input int id, input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_q.push_back({id_t'(id), hi, lo});
  endtask

  always @(negedge clk) begin
    #3;
    if (rst === 1'b0 && (bus.rsp_valid_o & bus.rsp_ready_i) != '0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid %b lo %h, expected no response",
                 bus.rsp_valid_o, bus.rsp_lo_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", bus.rsp_valid_o, id_onehot(mon_e[EW-1 -: IDW]));
        check("rsp_hi", bus.rsp_hi_o, mon_e[2*W-1:W]);
        check("rsp_lo", bus.rsp_lo_o, mon_e[W-1:0]);
      end
    end
  end

  // Driver
  logic [W-1:0] a_op [NREQ];
  logic [W-1:0] b_op [NREQ];

  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr);
    bus.req_valid_i = v;
    bus.rsp_ready_i = rr;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_a_i[k*W +: W] = a_op[k];
      bus.req_b_i[k*W +: W] = b_op[k];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    #2;
    while (bus.busy_o === 1'b1 && n < max) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({name, "_idle"}, bus.busy_o, 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] exp_ready;
  } vec_t;

  vec_t         vt [9];
  logic [W-1:0] rr_hi [NREQ];
  logic [W-1:0] rr_lo [NREQ];

  initial begin
    int issues;
    inject = 1'b0;
    drop   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      a_op[k] = '0;
      b_op[k] = '0;
    end
    rst = 1'b1;
    drive('0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #2;
    check("rst_req_ready", bus.req_ready_o, 0);
    check("rst_mul_valid", bus.mul_valid_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_err", bus.err_o, 0);
    @(negedge clk);

    // Single op: same-cycle grant, response visible 4 cycles later
    a_op[0] = 64'd3;
    b_op[0] = 64'd5;
    drive(4'b0001, 4'b0001);
    exp_push(0, 64'd0, 64'd15);
    #2;
    check("single_ready", bus.req_ready_o, 4'b0001);
    check("single_mul_valid", bus.mul_valid_o, 1);
    check("single_mul_a", bus.mul_a_o, 64'd3);
    check("single_mul_b", bus.mul_b_o, 64'd5);
    @(negedge clk);
    drive(4'b0000, 4'b0001);
    for (int c = 1; c < 4; c++) begin
      #2;
      check("single_early_rsp", bus.rsp_valid_o, 0);
      @(negedge clk);
    end
    #2;
    check("single_rsp_valid", bus.rsp_valid_o, 4'b0001);
    check("single_rsp_lo", bus.rsp_lo_o, 64'd15);
    check("single_rsp_hi", bus.rsp_hi_o, 64'd0);
    @(negedge clk);
    wait_idle(10, "single");

    // Round robin with all requesters valid; one credit stall after the first four
    do_reset();
    a_op[0] = 64'd6;                  b_op[0] = 64'd7;
    a_op[1] = 64'd100;                b_op[1] = 64'd100;
    a_op[2] = 64'hFFFF_FFFF_FFFF_FFFF; b_op[2] = 64'd5;
    a_op[3] = 64'h4000_0000_0000_0000; b_op[3] = 64'd8;
    rr_hi[0] = 64'd0;                   rr_lo[0] = 64'd42;
    rr_hi[1] = 64'd0;                   rr_lo[1] = 64'd10000;
    rr_hi[2] = 64'hFFFF_FFFF_FFFF_FFFF; rr_lo[2] = 64'hFFFF_FFFF_FFFF_FFFB;
    rr_hi[3] = 64'd2;                   rr_lo[3] = 64'd0;
    vt[0] = '{4'b1111, 4'b1111, 4'b0001};
    vt[1] = '{4'b1111, 4'b1111, 4'b0010};
    vt[2] = '{4'b1111, 4'b1111, 4'b0100};
    vt[3] = '{4'b1111, 4'b1111, 4'b1000};
    vt[4] = '{4'b1111, 4'b1111, 4'b0000};
    vt[5] = '{4'b1111, 4'b1111, 4'b0001};
    vt[6] = '{4'b1111, 4'b1111, 4'b0010};
    vt[7] = '{4'b1111, 4'b1111, 4'b0100};
    vt[8] = '{4'b1111, 4'b1111, 4'b1000};
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].valid, vt[i].rdy);
      #2;
      check("rr_ready", bus.req_ready_o, vt[i].exp_ready);
      check("rr_mul_valid", bus.mul_valid_o, |vt[i].exp_ready);
      for (int k = 0; k < NREQ; k++) begin
        if (vt[i].exp_ready[k]) begin
          check("rr_mul_a", bus.mul_a_o, a_op[k]);
          exp_push(k, rr_hi[k], rr_lo[k]);
        end
      end
      @(negedge clk);
    end
    drive(4'b0000, 4'b1111);
    wait_idle(20, "rr");

    // Backpressure: four credits, then one pop buys exactly one issue a cycle later
    do_reset();
    a_op[0] = 64'd3;
    b_op[0] = 64'd5;
    for (int i = 0; i < 5; i++) exp_push(0, 64'd0, 64'd15);
    drive(4'b0001, 4'b0000);
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      #2;
      check("bp_ready", bus.req_ready_o, (c < 4) ? 4'b0001 : 4'b0000);
      if (bus.mul_valid_o === 1'b1) issues++;
      @(negedge clk);
    end
    check("bp_issue_count", issues, 4);
    drive(4'b0001, 4'b0001);
    #2;
    check("bp_pop_cycle_no_issue", bus.mul_valid_o, 0);
    check("bp_head_valid", bus.rsp_valid_o, 4'b0001);
    @(negedge clk);
    drive(4'b0001, 4'b0000);
    #2;
    check("bp_issue_after_pop", bus.mul_valid_o, 1);
    @(negedge clk);
    #2;
    check("bp_credit_gone", bus.mul_valid_o, 0);
    @(negedge clk);
    drive(4'b0000, 4'b1111);
    wait_idle(20, "bp");

    // Signed boundary operands pass through unchanged
    a_op[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    b_op[1] = 64'd2;
    drive(4'b0010, 4'b1111);
    exp_push(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    #2;
    check("sb_ready", bus.req_ready_o, 4'b0010);
    @(negedge clk);
    drive(4'b0000, 4'b1111);
    repeat (3) @(negedge clk);
    #2;
    check("sb_rsp_valid", bus.rsp_valid_o, 4'b0010);
    check("sb_rsp_hi", bus.rsp_hi_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sb_rsp_lo", bus.rsp_lo_o, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    wait_idle(10, "sb");

    // Spurious result with nothing in flight: sticky error, FIFO untouched
    #2;
    check("inj_err_before", bus.err_o, 0);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #2;
    check("inj_err_set", bus.err_o, 1);
    check("inj_busy", bus.busy_o, 0);
    check("inj_rsp_valid", bus.rsp_valid_o, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #2;
      check("inj_err_held", bus.err_o, 1);
    end
    @(negedge clk);
    do_reset();
    #2;
    check("inj_err_cleared", bus.err_o, 0);
    @(negedge clk);

    // Missing result for a valid tag: tag dropped, credit recovered, error set
    a_op[2] = 64'd9;
    b_op[2] = 64'd9;
    drive(4'b0100, 4'b1111);
    #2;
    check("drop_ready", bus.req_ready_o, 4'b0100);
    @(negedge clk);
    drive(4'b0000, 4'b1111);
    repeat (2) @(negedge clk);
    drop = 1'b1;
    #2;
    check("drop_err_before", bus.err_o, 0);
    @(negedge clk);
    drop = 1'b0;
    #2;
    check("drop_err_set", bus.err_o, 1);
    check("drop_busy", bus.busy_o, 0);
    check("drop_rsp_valid", bus.rsp_valid_o, 0);
    @(negedge clk);
    do_reset();

    // Reset with three ops in flight flushes everything
    a_op[0] = 64'd2; b_op[0] = 64'd3;
    a_op[1] = 64'd4; b_op[1] = 64'd5;
    a_op[2] = 64'd6; b_op[2] = 64'd7;
    drive(4'b0111, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      #2;
      check("rmid_issue", bus.mul_valid_o, 1);
      @(negedge clk);
    end
    rst = 1'b1;
    drive(4'b0000, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rmid_busy", bus.busy_o, 0);
    check("rmid_rsp_valid", bus.rsp_valid_o, 0);
    check("rmid_err", bus.err_o, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #2;
      check("rmid_no_stale", bus.rsp_valid_o, 0);
    end
    @(negedge clk);
    a_op[3] = 64'd6;
    b_op[3] = 64'd7;
    drive(4'b1000, 4'b1111);
    exp_push(3, 64'd0, 64'd42);
    #2;
    check("rmid_fresh_ready", bus.req_ready_o, 4'b1000);
    @(negedge clk);
    drive(4'b0000, 4'b1111);
    wait_idle(20, "rmid");

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
